// File: rtl/mult_pipe.sv
// rtl/mult_pipe.sv - pipelined signed fixed-point multiplier with round/saturate and per-stage backpressure
module mult_pipe #(
  parameter int Width  = 32,
  parameter int Frac   = 21,
  parameter int Stages = 2,
  parameter int Round  = 0,
  parameter int Sat    = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] mult_o,
  output logic             ovf_o
);

  localparam int PW = 2 * Width;
  localparam logic [PW:0] RND = (Round != 0) ? ((PW+1)'(1) << (Frac - 1)) : '0;

  logic [Stages:1] v;
  logic [Stages:1] load;
  logic [Stages:1] drain;
  logic [Stages:1] in_v;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] fin_p;
  logic signed [PW:0]   p_rnd;
  logic signed [PW:0]   r;
  logic [Width-1:0]     fin_res;
  logic                 fin_ovf;

  assign a_ext = {{Width{a_i[Width-1]}}, a_i};
  assign b_ext = {{Width{b_i[Width-1]}}, b_i};
  assign prod  = a_ext * b_ext;

  // Resolve the handshake from the output slot back to the input so a
  // slot can accept in the same cycle its content moves downstream.
  always_comb begin
    load  = '0;
    drain = '0;
    in_v  = '0;
    drain[Stages] = v[Stages] & ready_i;
    load[Stages]  = ~v[Stages] | drain[Stages];
    for (int k = Stages - 1; k >= 1; k--) begin
      drain[k] = v[k] & load[k+1];
      load[k]  = ~v[k] | drain[k];
    end
    in_v[1] = valid_i;
    for (int k = 2; k <= Stages; k++) begin
      in_v[k] = v[k-1];
    end
  end

  assign ready_o = load[1];
  assign valid_o = v[Stages];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v <= '0;
    end else begin
      for (int k = 1; k <= Stages; k++) begin
        if (load[k]) v[k] <= in_v[k];
      end
    end
  end

  generate
    if (Stages == 1) begin : g_single
      assign fin_p = prod;
    end else begin : g_multi
      logic signed [PW-1:0] p_q [1:Stages-1];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int k = 1; k < Stages; k++) p_q[k] <= '0;
        end else begin
          if (load[1] && in_v[1]) p_q[1] <= prod;
          for (int k = 2; k < Stages; k++) begin
            if (load[k] && in_v[k]) p_q[k] <= p_q[k-1];
          end
        end
      end

      assign fin_p = p_q[Stages-1];
    end
  endgenerate

  // Rounding bias is added before the shift, so it takes part in the overflow test.
  always_comb begin
    p_rnd   = {fin_p[PW-1], fin_p} + RND;
    r       = p_rnd >>> Frac;
    fin_ovf = !((&r[PW:Width-1]) || !(|r[PW:Width-1]));
    if (fin_ovf && (Sat != 0)) begin
      fin_res = r[PW] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}};
    end else begin
      fin_res = r[Width-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mult_o <= '0;
      ovf_o  <= 1'b0;
    end else if (load[Stages] && in_v[Stages]) begin
      mult_o <= fin_res;
      ovf_o  <= fin_ovf;
    end
  end

endmodule

// File: tb/tb_mult_pipe.sv
// tb/tb_mult_pipe.sv - directed table-driven bench for mult_pipe across stage/round/sat variants
module tb_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] a_in;
  logic [31:0] b_in;

  logic [3:0]  vo;
  logic [3:0]  ro;
  logic [3:0]  ov;
  logic [31:0] mo [4];

  int n_chk  = 0;
  int n_fail = 0;
  int lat_exp [4] = '{2, 2, 1, 4};

  always #5 clk = ~clk;

  // 0: defaults, 1: round + wrap, 2: one stage, 3: four stages
  mult_pipe u_dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(ro[0]), .a_i(a_in), .b_i(b_in),
    .valid_o(vo[0]), .ready_i(ready_in), .mult_o(mo[0]), .ovf_o(ov[0])
  );
  mult_pipe #(.Round(1), .Sat(0)) u_rnd (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(ro[1]), .a_i(a_in), .b_i(b_in),
    .valid_o(vo[1]), .ready_i(ready_in), .mult_o(mo[1]), .ovf_o(ov[1])
  );
  mult_pipe #(.Stages(1)) u_s1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(ro[2]), .a_i(a_in), .b_i(b_in),
    .valid_o(vo[2]), .ready_i(ready_in), .mult_o(mo[2]), .ovf_o(ov[2])
  );
  mult_pipe #(.Stages(4)) u_s4 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(ro[3]), .a_i(a_in), .b_i(b_in),
    .valid_o(vo[3]), .ready_i(ready_in), .mult_o(mo[3]), .ovf_o(ov[3])
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_std;
    logic        o_std;
    logic [31:0] e_rnd;
    logic        o_rnd;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input string tag, input vec_t t);
    int          lat [4];
    int          cnt [4];
    logic [31:0] got [4];
    logic        gov [4];
    for (int j = 0; j < 4; j++) begin
      lat[j] = -1; cnt[j] = 0; got[j] = '0; gov[j] = 1'b0;
    end
    @(posedge clk); #1;
    valid_in = 1'b1; a_in = t.a; b_in = t.b; ready_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        if (vo[j]) begin
          cnt[j]++;
          if (lat[j] < 0) begin
            lat[j] = n; got[j] = mo[j]; gov[j] = ov[j];
          end
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      check($sformatf("%s_lat_i%0d", tag, j), 64'(lat[j]), 64'(lat_exp[j]));
      check($sformatf("%s_cnt_i%0d", tag, j), 64'(cnt[j]), 64'd1);
      check($sformatf("%s_val_i%0d", tag, j), 64'(got[j]), 64'(j == 1 ? t.e_rnd : t.e_std));
      check($sformatf("%s_ovf_i%0d", tag, j), 64'(gov[j]), 64'(j == 1 ? t.o_rnd : t.o_std));
    end
  endtask

  initial begin
    logic [31:0] q_rec [$];
    logic [31:0] held;
    logic [31:0] e;
    logic        acc;
    logic [15:0] pat [4];
    logic [15:0] pexp;
    int idx, rdy_low, stall_n, viol, first_after, last_c, stale;
    vec_t one;

    vecs[0] = '{32'h00200000, 32'h00200000, 32'h00200000, 1'b0, 32'h00200000, 1'b0};
    vecs[1] = '{32'h00300000, 32'h00300000, 32'h00480000, 1'b0, 32'h00480000, 1'b0};
    vecs[2] = '{32'h00300000, 32'hFFF00000, 32'hFFE80000, 1'b0, 32'hFFE80000, 1'b0};
    vecs[3] = '{32'h04000000, 32'h08000000, 32'h7FFFFFFF, 1'b1, 32'h00000000, 1'b1};
    vecs[4] = '{32'hFC000000, 32'h08000000, 32'h80000000, 1'b1, 32'h00000000, 1'b1};
    vecs[5] = '{32'h00000001, 32'h00100000, 32'h00000000, 1'b0, 32'h00000001, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 32'h00100000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0};
    vecs[7] = '{32'h7FFFFFFF, 32'h00200000, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b0};
    vecs[8] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 1'b1, 32'h00000000, 1'b1};

    rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(vo), 64'h0);
    check("rst_ovf", 64'(ov), 64'h0);
    check("rst_ready", 64'(ro), 64'hF);
    for (int j = 0; j < 4; j++) check($sformatf("rst_mult_i%0d", j), 64'(mo[j]), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_op($sformatf("v%0d", i), vecs[i]);

    // Backpressure on the default instance: stall cycles 3..5
    idx = 0; rdy_low = 0; stall_n = 0; viol = 0; first_after = -1; last_c = -1; held = '0;
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) begin
      valid_in = (idx < 8);
      a_in = 32'(idx + 1) << 21;
      b_in = (idx % 2 == 1) ? 32'hFFF00000 : 32'h00100000;
      ready_in = !(c >= 3 && c <= 5);
      @(negedge clk);
      if (!ro[0]) rdy_low++;
      if (vo[0] && !ready_in) begin
        if (stall_n > 0 && mo[0] !== held) viol++;
        held = mo[0];
        stall_n++;
      end
      if (vo[0] && ready_in) begin
        q_rec.push_back(mo[0]);
        if (c >= 6 && first_after < 0) first_after = c;
        last_c = c;
      end
      acc = valid_in && ro[0];
      @(posedge clk); #1;
      if (acc) idx++;
    end
    valid_in = 1'b0; ready_in = 1'b1;
    check("bp_ready_low_cycles", 64'(rdy_low), 64'd3);
    check("bp_stall_samples", 64'(stall_n), 64'd3);
    check("bp_stall_stable", 64'(viol), 64'd0);
    check("bp_count", 64'(q_rec.size()), 64'd8);
    check("bp_resume_cycle", 64'(first_after), 64'd6);
    check("bp_last_cycle", 64'(last_c), 64'd12);
    for (int k = 0; k < 8; k++) begin
      e = 32'(k + 1) << 20;
      if (k % 2 == 1) e = -e;
      check($sformatf("bp_data%0d", k), 64'(k < q_rec.size() ? q_rec[k] : 32'hDEADBEEF), 64'(e));
    end

    // Bubbles: 1,0,1,0... must reappear shifted by the latency
    for (int j = 0; j < 4; j++) pat[j] = '0;
    for (int c = 0; c < 16; c++) begin
      valid_in = (c < 8) && (c % 2 == 0);
      a_in = 32'h00200000; b_in = 32'h00200000;
      @(negedge clk);
      for (int j = 0; j < 4; j++) pat[j][c] = vo[j];
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    for (int j = 0; j < 4; j++) begin
      pexp = '0;
      for (int c = 0; c < 16; c++) begin
        pexp[c] = (c >= lat_exp[j]) && (c - lat_exp[j] < 8) && ((c - lat_exp[j]) % 2 == 0);
      end
      check($sformatf("bubble_pat_i%0d", j), 64'(pat[j]), 64'(pexp));
    end

    // Reset mid-stream with two results held in the default instance
    ready_in = 1'b0;
    valid_in = 1'b1; a_in = 32'h00300000; b_in = 32'h00300000;
    @(posedge clk); #1;
    a_in = 32'h00200000;
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("mid_inflight_valid", 64'(vo[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(vo), 64'h0);
    check("mid_rst_ovf", 64'(ov), 64'h0);
    for (int j = 0; j < 4; j++) check($sformatf("mid_rst_mult_i%0d", j), 64'(mo[j]), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", 64'(ro), 64'hF);
    ready_in = 1'b1;
    stale = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (vo != 4'h0) stale++;
    end
    check("mid_no_stale", 64'(stale), 64'd0);
    one = vecs[0];
    run_op("post_rst", one);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_pipe.md
Name: mult_pipe

Overview:
- Pipelined, parametrised signed fixed-point multiplier for the Lorenz attractor datapath.
- Successor to the combinational multiplier: adds configurable latency, a valid/ready handshake with per-stage backpressure, selectable rounding, and saturation with an overflow flag.
- Sits between the state registers and the Euler-integration adders.
- Default format is Q11.21, in 32-bit two's complement.

Parameters:
- Width, 32: operand and result width (signed two's complement).
- Frac, 21: fractional bits in operands and result; 1 <= Frac < Width.
- Stages, 2: pipeline depth (latency in cycles); legal range 1..4.
- Round, 0: 0 = truncate (arithmetic shift, floor); 1 = round half up (add 2^(Frac-1) before shift).
- Sat, 1: 1 = clamp on overflow; 0 = wrap (keep low Width bits).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- valid_i  in  1  input operands valid.
- ready_o  out  1  block can accept operands this cycle.
- a_i  in  Width  multiplicand, signed Q(Width-Frac).Frac.
- b_i  in  Width  multiplier, same format.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result this cycle.
- mult_o  out  Width  scaled product, same format.
- ovf_o  out  1  overflow flag, qualified by valid_o.

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0, valid_o = 0, mult_o = 0, ovf_o = 0. Operand data in flight is discarded.
- Transfers:
  - Input accepted on a cycle with valid_i && ready_o.
  - Output consumed on a cycle with valid_o && ready_i.
- Pipeline: Stages register slots, each with its own valid bit v[k]; slot Stages drives the outputs.
  - Stage k loads when !v[k] || adv[k+1]. adv[Stages] = ready_i && valid_o.
  - ready_o = !v[1] || adv[2]. For Stages = 1, ready_o = !valid_o || ready_i.
  - Bubbles collapse: an empty slot accepts even while downstream is stalled.
  - A stalled slot holds data and valid unchanged; no loss, no duplication.
- Latency: exactly Stages cycles from acceptance to valid_o, with no backpressure. Throughput is 1 per cycle.
- Arithmetic:
  - Full 2*Width signed product P = a*b.
  - If Round = 1: P' = P + 2^(Frac-1). Otherwise P' = P.
  - R = P' >>> Frac (arithmetic shift).
  - Overflow when R > 2^(Width-1)-1 or R < -2^(Width-1). The rounding addition is included in the overflow check.
  - Sat = 1: result clamps to 0x7FF..F or 0x800..0.
  - Sat = 0: result is R[Width-1:0].
  - ovf_o = 1 in either Sat mode whenever overflow occurred.
- Register boundaries:
  - Stages = 1: the single slot stores the final result and ovf.
  - Stages >= 2: slot 1 stores the full product P; the final slot stores the rounded and saturated result; intermediate slots pass the value through.
  - Internal retiming is allowed only if latency and the handshake are preserved.
- Output stability: mult_o and ovf_o are held stable while valid_o && !ready_i. When valid_o = 0 their values are don't-care but must not glitch to X after reset.
- Simultaneous accept and consume: in a full pipeline with ready_i = 1, ready_o = 1 and the stream flows unbroken.
- Reset asserted mid-stream: all in-flight results are dropped, ready_o = 1 after release, and the first post-reset result appears Stages cycles after the next accept.

Test Plan:
- Defaults, ready_i = 1: a = b = 0x00200000 (1.0) -> mult_o = 0x00200000, ovf_o = 0, valid_o exactly 2 cycles after accept. a = b = 0x00300000 (1.5) -> 0x00480000 (2.25). a = 0x00300000, b = 0xFFF00000 (-0.5) -> 0xFFE80000 (-0.75).
- Saturation (Sat = 1): 0x04000000 (32.0) * 0x08000000 (64.0) -> 0x7FFFFFFF, ovf_o = 1. 0xFC000000 (-32.0) * 0x08000000 -> 0x80000000, ovf_o = 1. With Sat = 0, the same positive case -> 0x00000000 (wrapped), ovf_o = 1.
- Rounding: 0x00000001 * 0x00100000 -> 0x00000000 (Round = 0) vs 0x00000001 (Round = 1). 0xFFFFFFFF * 0x00100000 -> 0xFFFFFFFF (Round = 0) vs 0x00000000 (Round = 1).
- Backpressure: stream 8 consecutive operand pairs with valid_i held high; drop ready_i for cycles 3..5. Check:
  - ready_o falls once the pipeline fills.
  - All 8 results arrive in order with no loss or duplication.
  - mult_o is stable during the stall.
  - Back-to-back throughput resumes when ready_i returns.
- Bubbles: valid_i alternates 1,0,1,0 with ready_i = 1 -> valid_o pattern is the same 1,0,1,0 shifted by Stages cycles. Repeat for Stages = 1 and 4, checking latency 1 and 4.
- Reset mid-operation: pull rst_ni low asynchronously, mid-cycle, with 2 results in flight -> valid_o = 0, mult_o = 0, ovf_o = 0 immediately. After release, ready_o = 1, no stale results emerge, and a new 1.0*1.0 returns 0x00200000 after Stages cycles.
